// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: FSM state codes, note codes,
// ROM entry layout and the built-in song contents.
package melody_pkg;

  localparam int unsigned NOTE_W  = 4;
  localparam int unsigned DUR_W   = 6;
  localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_PLAY = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS   = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS   = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd12;

  // Song ROM contents: {note, duration}; a zero duration marks the end.
  function automatic logic [ENTRY_W-1:0] song_entry(input int unsigned idx);
    case (idx)
      0:       return {NOTE_C,    6'd5};
      1:       return {NOTE_REST, 6'd3};
      2:       return {NOTE_E,    6'd2};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/melody_sequencer_tempo_tick.sv
// Tempo divider: emits a one-cycle tick every DIV enabled clock cycles.
// A synchronous clear restarts the count so the first tick lands DIV cycles
// after the clear is released.
module tempo_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Free-running modulo-DIV counter while enabled.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through the song ROM, holding each note for its
// duration in tempo ticks followed by a silent articulation gap, and drives
// note_code/note_on of the downstream tone generator.
// Optional feature macro: MELODY_LOOP_EN (honour the loop input).
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned SONG_LEN  = 16,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic                        CLOCK,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop,
  output logic [3:0]                  note_code,
  output logic                        note_on,
  output logic [$clog2(SONG_LEN)-1:0] step_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned IDX_W = $clog2(SONG_LEN);
  localparam logic [DUR_W-1:0] GAP_D = DUR_W'(GAP_TICKS);

  state_t             state;
  state_t             state_next;
  logic [ENTRY_W-1:0] rom_q;
  logic [ENTRY_W-1:0] next_entry;
  logic [NOTE_W-1:0]  entry_note;
  logic [DUR_W-1:0]   entry_dur;
  logic [DUR_W-1:0]   ticks_left;
  logic [DUR_W-1:0]   left_next;
  logic [IDX_W-1:0]   idx_next;
  logic [3:0]         code_next;
  logic               on_next;
  logic               done_next;
  logic               tick;
  logic               tick_clear;
  logic               tick_en;
  logic               loop_eff;

`ifdef MELODY_LOOP_EN
  assign loop_eff = loop;
`else
  assign loop_eff = loop & 1'b0;
`endif

  assign entry_note = rom_q[ENTRY_W-1 -: NOTE_W];
  assign entry_dur  = rom_q[DUR_W-1:0];

  // The ROM is addressed by the next index so the entry is ready in LOAD.
  assign next_entry = song_entry(32'(idx_next));

  assign tick_en    = (state == ST_PLAY) || (state == ST_GAP);
  assign tick_clear = !tick_en;

  tempo_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (CLOCK),
    .reset_n(reset_n),
    .clear  (tick_clear),
    .en     (tick_en),
    .tick   (tick)
  );

  // Next-state, next-index, duration count and next output values.
  always_comb begin
    state_next = state;
    idx_next   = step_idx;
    left_next  = ticks_left;
    code_next  = note_code;
    on_next    = note_on;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next = ST_LOAD;
          idx_next   = '0;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (entry_dur == '0) begin
          if (loop_eff) begin
            idx_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (entry_dur > GAP_D) begin
          state_next = ST_PLAY;
          left_next  = entry_dur - GAP_D;
          code_next  = entry_note;
          on_next    = (entry_note != NOTE_REST);
        end else begin
          // Too short to sound: the whole duration is spent silent.
          state_next = ST_GAP;
          left_next  = entry_dur;
          code_next  = entry_note;
          on_next    = 1'b0;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (ticks_left == 6'd1) begin
            on_next = 1'b0;
            if (GAP_TICKS == 0) begin
              state_next = ST_LOAD;
              idx_next   = step_idx + 1'b1;
            end else begin
              state_next = ST_GAP;
              left_next  = GAP_D;
            end
          end else begin
            left_next = ticks_left - 1'b1;
          end
        end
      end
      default: begin
        if (stop) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          if (ticks_left == 6'd1) begin
            state_next = ST_LOAD;
            idx_next   = step_idx + 1'b1;
          end else begin
            left_next = ticks_left - 1'b1;
          end
        end
      end
    endcase
    if (state_next == ST_IDLE) begin
      code_next = NOTE_REST;
      on_next   = 1'b0;
    end
    // done is registered, so it is raised on the edge entering the LOAD cycle
    // that will see the end marker.
    done_next = (state_next == ST_LOAD) && (next_entry[DUR_W-1:0] == '0) && !loop_eff;
  end

  // State, ROM read register and registered outputs.
  always_ff @(posedge CLOCK) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      step_idx   <= '0;
      ticks_left <= '0;
      rom_q      <= '0;
      note_code  <= NOTE_REST;
      note_on    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      step_idx   <= idx_next;
      ticks_left <= left_next;
      rom_q      <= next_entry;
      note_code  <= code_next;
      note_on    <= on_next;
      busy       <= (state_next != ST_IDLE);
      done       <= done_next;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with DIV=10, GAP_TICKS=2 and the song
// {C,5},{rest,3},{E,2},{end}. Cycle n is the state after the n-th rising
// edge counted from the edge that samples start; outputs are read 1 ns later.
module tb_melody_sequencer;

  logic       CLOCK = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [3:0] note_code;
  logic       note_on;
  logic [3:0] step_idx;
  logic       busy;
  logic       done;

  int tests = 0;
  int failed = 0;
  int now = 0;
  int done_cnt = 0;

  melody_sequencer #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .SONG_LEN (16),
    .GAP_TICKS(2)
  ) dut (
    .CLOCK    (CLOCK),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .note_code(note_code),
    .note_on  (note_on),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) if (reset_n && done) done_cnt++;

  task automatic go(input int target);
    while (now < target) begin
      @(posedge CLOCK);
      #1;
      now++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, now, obs, exp);
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_code", 32'(note_code), 32'd0);
    chk("rst_on",   32'(note_on),   32'd0);
    chk("rst_idx",  32'(step_idx),  32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_done", 32'(done),      32'd0);
    reset_n = 1'b1;
    @(posedge CLOCK);
    #1;

    // Full playback, loop low
    start = 1'b1;
    now = 0;
    go(1);
    start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_on",   32'(note_on), 32'd0);
    go(2);
    chk("play_code", 32'(note_code), 32'd1);
    chk("play_on",   32'(note_on),   32'd1);
    chk("play_busy", 32'(busy),      32'd1);
    chk("play_idx",  32'(step_idx),  32'd0);
    for (int c = 3; c <= 31; c++) begin
      go(c);
      chk("c_on_high", 32'(note_on), 32'd1);
    end
    for (int c = 32; c <= 51; c++) begin
      go(c);
      chk("c_gap_on", 32'(note_on), 32'd0);
      chk("c_gap_code", 32'(note_code), 32'd1);
    end
    go(52);
    chk("load1_idx", 32'(step_idx), 32'd1);
    chk("load1_busy", 32'(busy), 32'd1);
    for (int c = 53; c <= 82; c++) begin
      go(c);
      chk("rest_on", 32'(note_on), 32'd0);
      chk("rest_code", 32'(note_code), 32'd0);
    end
    go(83);
    chk("load2_idx", 32'(step_idx), 32'd2);
    for (int c = 84; c <= 103; c++) begin
      go(c);
      chk("e_on", 32'(note_on), 32'd0);
      chk("e_code", 32'(note_code), 32'd5);
      chk("e_busy", 32'(busy), 32'd1);
    end
    chk("e_no_done", 32'(done), 32'd0);
    go(104);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd1);
    chk("end_idx",  32'(step_idx), 32'd3);
    go(105);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_code", 32'(note_code), 32'd0);
    chk("post_on",   32'(note_on), 32'd0);
    chk("done_once", 32'(done_cnt), 32'd1);

    // Stop mid-PLAY, then stop beating start in IDLE
    start = 1'b1;
    now = 0;
    go(1);
    start = 1'b0;
    go(5);
    chk("stop_pre_on", 32'(note_on), 32'd1);
    stop = 1'b1;
    go(6);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_on",   32'(note_on), 32'd0);
    chk("stop_code", 32'(note_code), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    start = 1'b1;
    go(8);
    chk("stop_wins", 32'(busy), 32'd0);
    stop = 1'b0;
    go(9);
    chk("restart_busy", 32'(busy), 32'd1);
    go(10);
    chk("restart_code", 32'(note_code), 32'd1);
    stop = 1'b1;
    start = 1'b0;
    go(11);
    chk("stop2_busy", 32'(busy), 32'd0);
    stop = 1'b0;
    chk("stop_no_done", 32'(done_cnt), 32'd1);
    go(13);

    // Loop request at the end marker
    loop = 1'b1;
    start = 1'b1;
    now = 0;
    go(1);
    start = 1'b0;
    go(104);
    chk("loop_idx_end", 32'(step_idx), 32'd3);
`ifdef MELODY_LOOP_EN
    chk("loop_no_done", 32'(done), 32'd0);
    go(105);
    chk("loop_idx0",  32'(step_idx), 32'd0);
    chk("loop_busy",  32'(busy), 32'd1);
    go(106);
    chk("loop_code",  32'(note_code), 32'd1);
    chk("loop_on",    32'(note_on), 32'd1);
    stop = 1'b1;
    go(107);
    stop = 1'b0;
    chk("loop_stop_busy", 32'(busy), 32'd0);
    chk("loop_done_cnt", 32'(done_cnt), 32'd1);
`else
    chk("noloop_done", 32'(done), 32'd1);
    go(105);
    chk("noloop_busy", 32'(busy), 32'd0);
    chk("noloop_done_cnt", 32'(done_cnt), 32'd2);
`endif
    loop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
